int_ctrl: RTL
=============

# int_ctrl

Programmable interrupt controller between the memory-mapped devices (timers, I/O) and the CP0 `HWInt[5:0]` input. Per source, it latches level or edge requests and applies a software mask. It tracks which source is in service, with one level of preemption, so that `hwint` presents only sources of strictly higher priority than the one being serviced. Software configures it through the system bridge as a 4-word register window.

## Interface
Parameters:
- `N_SRC`, 6: number of interrupt sources; equals the CP0 `HWInt` width; source 5 has highest priority.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `irq_in`  in  N_SRC  device request lines, synchronous to `clk`.
- `we`  in  1  bridge register write strobe.
- `addr`  in  2  word offset (bridge address bits [3:2]).
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational from `addr`.
- `int_taken`  in  1  one-cycle pulse: pipeline committed an interrupt exception (CP0 `IntReq` with ExcCode 0).
- `eret`  in  1  one-cycle pulse: `eret` committed.
- `hwint`  out  N_SRC  to CP0 `HWInt`.

## Operation
Registers, by word offset:
- **0 MASK[5:0]** R/W. Reset 0.
- **1 MODE[5:0]** R/W. 0 = level, 1 = edge. Reset 0.
- **2 PEND[5:0]** R. Writing 1 clears edge-mode bits; level bits ignore writes.
- **3 STATUS** R. Bits [1:0] = depth, [6:4] = top id, [10:8] = saved id. Writes ignored.
- Upper `rdata` bits read 0.

Request latching:
- `irq_q` is `irq_in` registered.
- Level bit: `pend[i]` <= `irq_in[i]`.
- Edge bit: set on `irq_in[i] & ~irq_q[i]`; held until cleared by W1C or by a claim.
- If set and clear hit the same edge, set wins.
- Changing MODE from 1 to 0 makes the bit track the level from the next edge.

Service states, encoded by depth:
- **IDLE** (depth 0). `allow` = all ones.
- **SVC1** (depth 1). `allow` = only sources with index > top id.
- **SVC2** (depth 2). `allow` = 0.
- `hwint` = `pend & MASK & allow`, combinational from flops.

Claim, on `int_taken`:
- `win` = highest set bit of `hwint`.
- IDLE to SVC1: top <= win.
- SVC1 to SVC2: saved <= top, top <= win.
- If `win` is edge-mode, its pend bit is cleared.
- If `hwint` == 0 (spurious): no state change.
- In SVC2: ignored.

Return, on `eret`:
- SVC2 to SVC1: top <= saved.
- SVC1 to IDLE.
- IDLE: ignored.

Simultaneous `eret` and `int_taken`:
- The pop is applied first, then the claim is evaluated against the popped state's `allow`, all in one edge.
- SVC1 with both: ends in SVC1 with the new top if a claim exists, otherwise IDLE.
- IDLE with both: claim only.

## Timing
- Reset (asynchronous): MASK, MODE, pend, `irq_q` = 0; state IDLE; ids 0. Outputs `hwint` = 0; `rdata` = 0 for offsets 2 and 3.
- `irq_in` rises before edge k: pend is set at k, and `hwint` is high during cycle k+1 if masked in. One-cycle latency.
- MASK write at edge k: affects `hwint` from cycle k+1.
- `int_taken` at edge k: `hwint` reflects the new `allow` and the cleared pend from cycle k+1. CP0 samples `HWInt` each cycle, so the claimed source is not re-raised.
- Reads have zero latency. A same-cycle write is visible only after the edge.
- Reset asserted mid-service drops to IDLE immediately; no `eret` is required.

## Structure
- Package `int_ctrl_pkg` holds:
  - `N_SRC`
  - offsets `ADDR_MASK`=0, `ADDR_MODE`=1, `ADDR_PEND`=2, `ADDR_STATUS`=3
  - depth encoding `ST_IDLE`=0, `ST_SVC1`=1, `ST_SVC2`=2
  - field positions of STATUS
- Sub-module `int_prio_enc`: N_SRC-bit vector to {valid, 3-bit index of highest set bit}. Used for `win`; also reusable for the `allow` threshold decode.

## Test plan
- **Edge capture and W1C.** MODE=0x04, MASK=0x04; pulse `irq_in[2]` for 1 cycle. `hwint`=0x04 one cycle later and stays high after the pulse. Write PEND=0x04: `hwint`=0x00 next cycle.
- **Level tracking.** MODE=0, MASK=0x3F; hold `irq_in[0]` high, then drop it. `hwint[0]` follows with 1-cycle lag. W1C has no effect.
- **Claim and preemption.** Sources 1 and 4 pending (edge); `int_taken`.
  - STATUS depth=1, id=4; `hwint`=0x00 (1 < 4).
  - Raise 5, `int_taken`: depth=2, top=5, saved=4, `hwint`=0.
  - `eret`: top=4.
  - `eret`: IDLE, `hwint`=0x02.
- **Spurious and overflow.** `int_taken` with `hwint`=0: STATUS unchanged. In SVC2, `int_taken`: no change.
- **Simultaneous `eret`+`int_taken` in SVC1** (top=3) with source 2 pending: ends SVC1, top=2.
- **Reset mid-service.** In SVC2 with pend=0x3F, assert `reset` between edges: `hwint`=0 and STATUS=0 immediately.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants and types for the interrupt controller.
//   N_SRC          number of interrupt sources (matches CP0 HWInt width)
//   ID_W           width of a source index
//   ADDR_*         word offsets of the register window
//   svc_state_t    service depth encoding (IDLE / SVC1 / SVC2)
//   STAT_*_LSB     field positions inside the STATUS register
package int_ctrl_pkg;

    localparam int N_SRC = 6;
    localparam int ID_W  = 3;

    localparam logic [1:0] ADDR_MASK   = 2'd0;
    localparam logic [1:0] ADDR_MODE   = 2'd1;
    localparam logic [1:0] ADDR_PEND   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SVC1 = 2'd1,
        ST_SVC2 = 2'd2
    } svc_state_t;

    localparam int STAT_DEPTH_LSB = 0;
    localparam int STAT_TOP_LSB   = 4;
    localparam int STAT_SAVED_LSB = 8;

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: priority encoder, highest set bit wins.
//   vec    in   N      request vector
//   valid  out  1      any bit of vec set
//   idx    out  IDX_W  index of the highest set bit (0 when none)
module int_prio_enc #(
    parameter int N     = 6,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Ascending scan: later (higher) indices overwrite earlier ones.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: programmable interrupt controller feeding CP0 HWInt.
// Latches level/edge requests per source, applies a mask and tracks the
// source in service with one level of preemption.
//   clk        in   1      system clock
//   reset      in   1      asynchronous active-high reset
//   irq_in     in   N_SRC  device request lines
//   we         in   1      register write strobe
//   addr       in   2      word offset: 0 MASK, 1 MODE, 2 PEND, 3 STATUS
//   wdata      in   32     write data
//   rdata      out  32     combinational read data
//   int_taken  in   1      interrupt exception committed (claim)
//   eret       in   1      eret committed (return)
//   hwint      out  N_SRC  pend & mask & allow
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_SRC = int_ctrl_pkg::N_SRC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic             int_taken,
    input  logic             eret,
    output logic [N_SRC-1:0] hwint
);

    logic [N_SRC-1:0] mask_reg;
    logic [N_SRC-1:0] mode_reg;
    logic [N_SRC-1:0] pend_reg;
    logic [N_SRC-1:0] pend_next;
    logic [N_SRC-1:0] irq_q_reg;

    svc_state_t       state_reg, state_next;
    logic [ID_W-1:0]  top_reg, top_next;
    logic [ID_W-1:0]  saved_reg, saved_next;

    // State after applying a pending eret; claims are judged against it.
    svc_state_t       pop_state;
    logic [ID_W-1:0]  pop_top;

    logic [N_SRC-1:0] above_cur, above_pop;
    logic [N_SRC-1:0] allow_cur, allow_pop;
    logic [N_SRC-1:0] hwint_pop;
    logic             win_valid;
    logic [ID_W-1:0]  win_id;
    logic             claim_fire;
    logic [N_SRC-1:0] w1c_clr, claim_clr, pend_clr;

    // ---------------- threshold decode and request latching ----------------
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign above_cur[gi] = (ID_W'(gi) > top_reg);
            assign above_pop[gi] = (ID_W'(gi) > pop_top);
            // Edge bits: a new rising edge beats a same-cycle clear.
            assign pend_next[gi] = mode_reg[gi]
                ? ((irq_in[gi] & ~irq_q_reg[gi]) | (pend_reg[gi] & ~pend_clr[gi]))
                : irq_in[gi];
        end
    endgenerate

    assign w1c_clr   = (we && addr == ADDR_PEND) ? wdata[N_SRC-1:0] : '0;
    assign claim_clr = claim_fire ? (N_SRC'(1) << win_id) : '0;
    assign pend_clr  = w1c_clr | claim_clr;

    always_comb begin
        allow_cur = '0;
        case (state_reg)
            ST_IDLE: allow_cur = '1;
            ST_SVC1: allow_cur = above_cur;
            default: allow_cur = '0;
        endcase
    end

    assign hwint = pend_reg & mask_reg & allow_cur;

    // ---------------- return (pop) stage ----------------
    always_comb begin
        pop_state = state_reg;
        pop_top   = top_reg;
        if (eret) begin
            case (state_reg)
                ST_SVC2: begin
                    pop_state = ST_SVC1;
                    pop_top   = saved_reg;
                end
                ST_SVC1: pop_state = ST_IDLE;
                default: pop_state = state_reg;
            endcase
        end
    end

    always_comb begin
        allow_pop = '0;
        case (pop_state)
            ST_IDLE: allow_pop = '1;
            ST_SVC1: allow_pop = above_pop;
            default: allow_pop = '0;
        endcase
    end

    assign hwint_pop = pend_reg & mask_reg & allow_pop;

    int_prio_enc #(
        .N     (N_SRC),
        .IDX_W (ID_W)
    ) u_win_enc (
        .vec   (hwint_pop),
        .valid (win_valid),
        .idx   (win_id)
    );

    // ---------------- claim stage / next state ----------------
    // In SVC2 allow_pop is zero, so win_valid is never set there.
    always_comb begin
        state_next = pop_state;
        top_next   = pop_top;
        saved_next = saved_reg;
        claim_fire = 1'b0;
        if (int_taken && win_valid) begin
            case (pop_state)
                ST_IDLE: begin
                    claim_fire = 1'b1;
                    state_next = ST_SVC1;
                    top_next   = win_id;
                end
                ST_SVC1: begin
                    claim_fire = 1'b1;
                    state_next = ST_SVC2;
                    saved_next = pop_top;
                    top_next   = win_id;
                end
                default: claim_fire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            top_reg   <= '0;
            saved_reg <= '0;
        end else begin
            state_reg <= state_next;
            top_reg   <= top_next;
            saved_reg <= saved_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_reg  <= '0;
            mode_reg  <= '0;
            pend_reg  <= '0;
            irq_q_reg <= '0;
        end else begin
            pend_reg  <= pend_next;
            irq_q_reg <= irq_in;
            if (we && addr == ADDR_MASK) mask_reg <= wdata[N_SRC-1:0];
            if (we && addr == ADDR_MODE) mode_reg <= wdata[N_SRC-1:0];
        end
    end

    // ---------------- register read ----------------
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_MASK: rdata[N_SRC-1:0] = mask_reg;
            ADDR_MODE: rdata[N_SRC-1:0] = mode_reg;
            ADDR_PEND: rdata[N_SRC-1:0] = pend_reg;
            default: begin
                rdata[STAT_DEPTH_LSB +: 2]  = state_reg;
                rdata[STAT_TOP_LSB +: ID_W]   = top_reg;
                rdata[STAT_SAVED_LSB +: ID_W] = saved_reg;
            end
        endcase
    end

endmodule
